// File: rtl/div_nr_sm.sv
// Multi-cycle non-restoring integer divider with signed/unsigned mode,
// divide-by-zero and signed-overflow short paths, and a start/done handshake.
module div_nr_sm #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         dbz
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
    localparam logic [n-1:0]  ZERO_N   = {n{1'b0}};
    localparam logic [n-1:0]  ONES_N   = {n{1'b1}};
    localparam logic [n-1:0]  ONE_N    = {{(n-1){1'b0}}, 1'b1};
    localparam logic [n-1:0]  MIN_N    = {1'b1, {(n-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [n-1:0] neg_f(input logic [n-1:0] v);
        return ~v + ONE_N;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n:0]    prem_q, prem_d;   // signed partial remainder
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dbzp_q, dbzp_d;
    logic [n-1:0]  quotient_q, quotient_d;
    logic [n-1:0]  remainder_q, remainder_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          dbz_q, dbz_d;

    logic [n-1:0]  dvd_abs;
    logic [n-1:0]  dvs_abs;
    logic [n:0]    prem_sh;
    logic [n:0]    prem_new;
    logic [n:0]    prem_fix;

    // Next-state, datapath and output computation for every state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dbzp_d      = dbzp_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        dbz_d       = dbz_q;

        dvd_abs  = (signed_mode && dividend[n-1]) ? neg_f(dividend) : dividend;
        dvs_abs  = (signed_mode && divisor[n-1])  ? neg_f(divisor)  : divisor;
        prem_sh  = {prem_q[n-1:0], dvd_q[n-1]};
        prem_new = prem_q[n] ? (prem_sh + {1'b0, dvs_q}) : (prem_sh - {1'b0, dvs_q});
        prem_fix = prem_q[n] ? (prem_q + {1'b0, dvs_q}) : prem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    cnt_d  = {CW{1'b0}};
                    qneg_d = signed_mode & (dividend[n-1] ^ divisor[n-1]);
                    rneg_d = signed_mode & dividend[n-1];
                    if (divisor == ZERO_N) begin
                        state_d = FIN;
                        dvd_d   = ONES_N;
                        dvs_d   = divisor;
                        prem_d  = {1'b0, dividend};
                        dbzp_d  = 1'b1;
                    end else if (signed_mode && (dividend == MIN_N) && (divisor == ONES_N)) begin
                        state_d = FIN;
                        dvd_d   = MIN_N;
                        dvs_d   = divisor;
                        prem_d  = {(n+1){1'b0}};
                        dbzp_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        dvd_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        prem_d  = {(n+1){1'b0}};
                        dbzp_d  = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                prem_d = prem_new;
                dvd_d  = {dvd_q[n-2:0], ~prem_new[n]};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                dvd_d   = qneg_q ? neg_f(dvd_q) : dvd_q;
                prem_d  = {1'b0, (rneg_q ? neg_f(prem_fix[n-1:0]) : prem_fix[n-1:0])};
                busy_d  = 1'b0;
                state_d = FIN;
            end
            FIN: begin
                quotient_d  = dvd_q;
                remainder_d = prem_q[n-1:0];
                dbz_d       = dbzp_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            dvd_q       <= {n{1'b0}};
            dvs_q       <= {n{1'b0}};
            prem_q      <= {(n+1){1'b0}};
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbzp_q      <= 1'b0;
            quotient_q  <= {n{1'b0}};
            remainder_q <= {n{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dbzp_q      <= dbzp_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_nr_sm.sv
// Directed bench for div_nr_sm (n = 8): results, latency, busy/done timing,
// short paths, handshake corner cases and mid-operation reset.
module tb_div_nr_sm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       done;
    logic       busy;
    logic       dbz;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic dbz_k1;

    div_nr_sm #(.n(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .dbz        (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
    endtask

    // Waits for done; lat counts rising edges from the sampling edge to done.
    task automatic wait_done(input int repulse_k, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start  = 1'b0;
                dbz_k1 = dbz;
            end
            if (k == repulse_k) begin
                issue(8'h64, 8'h05, 1'b1);
            end
            if (k == repulse_k + 1) begin
                start    = 1'b0;
                dividend = 8'hAA;
                divisor  = 8'h01;
            end
            if (done) begin
                lat = k - 1;
                break;
            end
            if (busy) bcnt++;
        end
        if (lat < 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sm, input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input int elat, input int repulse, input logic hold);
        int lat;
        int bcnt;
        issue(a, b, sm);
        wait_done(repulse, lat, bcnt);
        chk({tag, "_lat"},  lat, elat);
        chk({tag, "_busy"}, bcnt, (elat == 1) ? 1 : elat - 1);
        chk({tag, "_q"},    {24'd0, quotient}, {24'd0, eq});
        chk({tag, "_r"},    {24'd0, remainder}, {24'd0, er});
        chk({tag, "_dbz"},  {31'd0, dbz}, {31'd0, edbz});
        chk({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
        if (hold) begin
            @(negedge clk);
            chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_hold"}, {16'd0, quotient, remainder}, {16'd0, eq, er});
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = 8'h00;
        divisor     = 8'h00;
        dbz_k1      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {13'd0, quotient, remainder, done, busy, dbz}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("u23_3",   8'h17, 8'h03, 1'b0, 8'h07, 8'h02, 1'b0, 10, 0, 1'b1);
        run("sm23_3",  8'hE9, 8'h03, 1'b1, 8'hF9, 8'hFE, 1'b0, 10, 0, 1'b1);
        run("s23_m3",  8'h17, 8'hFD, 1'b1, 8'hF9, 8'h02, 1'b0, 10, 0, 1'b1);
        run("sm128_7", 8'h80, 8'h07, 1'b1, 8'hEE, 8'hFE, 1'b0, 10, 0, 1'b1);
        run("u255_1",  8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 10, 0, 1'b1);
        run("u255_16", 8'hFF, 8'h10, 1'b0, 8'h0F, 8'h0F, 1'b0, 10, 0, 1'b1);
        run("dbz_u",   8'h17, 8'h00, 1'b0, 8'hFF, 8'h17, 1'b1, 1, 0, 1'b1);
        run("dbz_s",   8'h17, 8'h00, 1'b1, 8'hFF, 8'h17, 1'b1, 1, 0, 1'b1);
        run("after_dbz", 8'h17, 8'h03, 1'b0, 8'h07, 8'h02, 1'b0, 10, 0, 1'b1);
        chk("dbz_clear", {31'd0, dbz_k1}, 32'd0);
        run("ovf_s",   8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1, 0, 1'b1);
        run("ovf_u",   8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 10, 0, 1'b1);
        run("u200_255", 8'hC8, 8'hFF, 1'b0, 8'h00, 8'hC8, 1'b0, 10, 0, 1'b1);

        // re-pulse of start with new operands mid-operation must be ignored
        run("repulse", 8'h17, 8'h03, 1'b0, 8'h07, 8'h02, 1'b0, 10, 4, 1'b1);

        // start during the done cycle is accepted immediately
        run("b2b_a",   8'h64, 8'h07, 1'b0, 8'h0E, 8'h02, 1'b0, 10, 0, 1'b0);
        run("b2b_b",   8'hC8, 8'h0B, 1'b1, 8'hFB, 8'hFF, 1'b0, 10, 0, 1'b1);

        // asynchronous reset between clock edges aborts the operation
        issue(8'h17, 8'h03, 1'b0);
        repeat (5) @(negedge clk) start = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("mid_rst_outs", {13'd0, quotient, remainder, done, busy, dbz}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) bcnt++;
        end
        chk("no_done_after_rst", bcnt, 0);
        run("post_rst", 8'h17, 8'h03, 1'b0, 8'h07, 8'h02, 1'b0, 10, 0, 1'b1);

        lat = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
